// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-fetch responder with fixed-latency pipeline, credit backpressure and response FIFO
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] ERR_INST    = 32'h00100073,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [31:0]   rsp_cnt
);
    localparam int          PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          legal;
    logic [AW-1:0] index;
    logic [31:0]   fetch_word;
    logic          accept;
    logic          push;
    logic          pop;

    // Offset compare in 33 bits so a window ending at 2^32 cannot wrap.
    assign offset     = req_addr - BASE_ADDR;
    assign legal      = (req_addr[1:0] == 2'b00) && (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign index      = offset[AW+1:2];
    assign fetch_word = legal ? mem[index] : ERR_INST;

    // Read is combinational before the edge, so a same-cycle load is seen only by later fetches.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] pe;
    logic [31:0]        pd [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
        pd[0] <= fetch_word;
        pe[0] <= !legal;
        for (int i = 1; i < LATENCY; i++) begin
            pd[i] <= pd[i-1];
            pe[i] <= pe[i-1];
        end
    end

    logic [31:0]           fd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fe;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         used;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // used = pipeline valids + FIFO entries; stage-to-FIFO moves leave it unchanged.
    assign req_ready = !reset && (used < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = pv[LATENCY-1];
    assign rsp_valid = (occ != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fd[rd_ptr] : ERR_INST;
    assign rsp_err   = rsp_valid && fe[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fd[wr_ptr] <= pd[LATENCY-1];
            fe[wr_ptr] <= pe[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            used    <= '0;
            rsp_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= next_ptr(rd_ptr);
                rsp_cnt <= rsp_cnt + 32'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            case ({accept, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed and randomized self-checking bench for imem_responder
module tb_imem_responder;
    localparam logic [31:0] BASE = 32'h80000000;
    localparam logic [31:0] ERR  = 32'h00100073;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] rsp_cnt;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          exp_cnt = 0;
    logic [31:0] expmem [8];

    always #5 clk = ~clk;

    imem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rsp_cnt(rsp_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 10'(idx); ld_data = d;
        step();
        ld_en = 1'b0;
        if (idx < 8) expmem[idx] = d;
    endtask

    // Drives one request with rsp_ready=1 and samples the head LATENCY cycles later, then lets it pop.
    task automatic fetch_one(input logic [31:0] a, output logic v, output logic [31:0] d, output logic e);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
        step();
        step();
        v = rsp_valid; d = rsp_data; e = rsp_err;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        tests_run++; if (rsp_data !== ERR) begin tests_failed++; $display("FAIL reset_rsp_data: got %h want %h", rsp_data, ERR); end
        tests_run++; if (rsp_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_cnt: got %0d want 0", rsp_cnt); end
        reset = 1'b0;
        step();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = BASE;
        step();
        req_addr = BASE + 32'd4;
        step();
        req_valid = 1'b0;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early: rsp_valid got %b want 0", rsp_valid); end
        step();
        tests_run++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h00500093}) begin
            tests_failed++; $display("FAIL basic_rsp0: v=%b e=%b d=%h want v=1 e=0 d=00500093", rsp_valid, rsp_err, rsp_data); end
        step();
        tests_run++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h00108113}) begin
            tests_failed++; $display("FAIL basic_rsp1: v=%b e=%b d=%h want v=1 e=0 d=00108113", rsp_valid, rsp_err, rsp_data); end
        step();
        exp_cnt = 2;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_drained: rsp_valid got %b want 0", rsp_valid); end
        tests_run++; if (rsp_cnt !== 32'(exp_cnt)) begin tests_failed++; $display("FAIL basic_cnt: got %0d want %0d", rsp_cnt, exp_cnt); end
    endtask

    task automatic test_error();
        logic [31:0] addrs [4];
        logic [31:0] wd [4];
        logic        we [4];
        logic        v, e;
        logic [31:0] d;
        addrs = '{32'h80001000, 32'h80000002, 32'h7FFFFFFC, 32'h80000FFC};
        wd    = '{ERR, ERR, ERR, 32'h0000006F};
        we    = '{1'b1, 1'b1, 1'b1, 1'b0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_one(addrs[i], v, d, e);
            exp_cnt++;
            tests_run++; if ({v, e, d} !== {1'b1, we[i], wd[i]}) begin
                tests_failed++; $display("FAIL error_%0d addr=%h: v=%b e=%b d=%h want v=1 e=%b d=%h", i, addrs[i], v, e, d, we[i], wd[i]); end
        end
        tests_run++; if (rsp_cnt !== 32'(exp_cnt)) begin tests_failed++; $display("FAIL error_cnt: got %0d want %0d", rsp_cnt, exp_cnt); end
    endtask

    task automatic test_full();
        int n = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_addr = BASE + 32'(4 * n);
            if (req_ready) n++;
            step();
        end
        req_valid = 1'b0;
        tests_run++; if (n != 4) begin tests_failed++; $display("FAIL full_accepts: got %0d want 4", n); end
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b want 0", req_ready); end
        tests_run++; if (rsp_data !== expmem[0]) begin tests_failed++; $display("FAIL full_head: got %h want %h", rsp_data, expmem[0]); end
        step();
        tests_run++; if ({rsp_valid, rsp_data} !== {1'b1, expmem[0]}) begin
            tests_failed++; $display("FAIL full_hold: v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, expmem[0]); end
        rsp_ready = 1'b1;
        step();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_return: got %b want 1", req_ready); end
        for (int k = 1; k < 4; k++) begin
            tests_run++; if ({rsp_valid, rsp_data} !== {1'b1, expmem[k]}) begin
                tests_failed++; $display("FAIL full_order_%0d: v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, expmem[k]); end
            step();
        end
        exp_cnt += 4;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drained: rsp_valid got %b want 0", rsp_valid); end
        tests_run++; if (rsp_cnt !== 32'(exp_cnt)) begin tests_failed++; $display("FAIL full_cnt: got %0d want %0d", rsp_cnt, exp_cnt); end
    endtask

    task automatic test_load_collision();
        logic        v, e;
        logic [31:0] d;
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 10'd3; ld_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = BASE + 32'hC;
        step();
        ld_en = 1'b0; req_valid = 1'b0;
        expmem[3] = 32'hDEADBEEF;
        step(); step();
        tests_run++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h00000013}) begin
            tests_failed++; $display("FAIL collide_old: v=%b e=%b d=%h want v=1 e=0 d=00000013", rsp_valid, rsp_err, rsp_data); end
        step();
        fetch_one(BASE + 32'hC, v, d, e);
        exp_cnt += 2;
        tests_run++; if ({v, e, d} !== {2'b10, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL collide_new: v=%b e=%b d=%h want v=1 e=0 d=deadbeef", v, e, d); end
        tests_run++; if (rsp_cnt !== 32'(exp_cnt)) begin tests_failed++; $display("FAIL collide_cnt: got %0d want %0d", rsp_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = BASE + 32'(4 * i);
            step();
        end
        reset = 1'b1;
        #1;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_ready_in_reset: got %b want 0", req_ready); end
        step();
        reset = 1'b0; req_valid = 1'b0;
        #1;
        exp_cnt = 0;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        tests_run++; if (rsp_cnt !== 32'd0) begin tests_failed++; $display("FAIL midrst_cnt: got %0d want 0", rsp_cnt); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen++;
            step();
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL midrst_ghost: %0d responses seen want 0", seen); end
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [32:0] ent;
        logic [32:0] got;
        int          r;
        int          npop = 0;
        for (int c = 0; c < 1000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 8) begin
                req_addr = BASE + 32'(4 * r); ent = {1'b0, expmem[r]};
            end else begin
                req_addr = (r == 8) ? 32'h80000002 : 32'h80001000; ent = {1'b1, ERR};
            end
            tests_run++; if (req_ready !== (q.size() < 4)) begin
                tests_failed++; $display("FAIL rand_credit c=%0d: req_ready=%b outstanding=%0d", c, req_ready, q.size()); end
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                got = {rsp_err, rsp_data};
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL rand_extra c=%0d: got %h with nothing outstanding", c, got);
                end else begin
                    ent = (r < 8) ? {1'b0, expmem[r]} : {1'b1, ERR};
                    if (got !== q[0]) begin tests_failed++; $display("FAIL rand_data c=%0d: got %h want %h", c, got, q[0]); end
                    void'(q.pop_front());
                    npop++;
                end
            end
            if (req_valid && req_ready) q.push_back(ent);
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) begin
                tests_run++;
                got = {rsp_err, rsp_data};
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL rand_drain_extra: got %h", got);
                end else begin
                    if (got !== q[0]) begin tests_failed++; $display("FAIL rand_drain_data: got %h want %h", got, q[0]); end
                    void'(q.pop_front());
                    npop++;
                end
            end
            step();
        end
        tests_run++; if (q.size() != 0) begin tests_failed++; $display("FAIL rand_lost: %0d responses missing", q.size()); end
        tests_run++; if (rsp_cnt !== 32'(npop)) begin tests_failed++; $display("FAIL rand_cnt: got %0d want %0d", rsp_cnt, npop); end
    endtask

    initial begin
        test_reset();
        load_word(0, 32'h00500093);
        load_word(1, 32'h00108113);
        load_word(2, 32'h00208193);
        load_word(3, 32'h00000013);
        for (int i = 4; i < 8; i++) load_word(i, 32'h10000000 + 32'(i));
        load_word(1023, 32'h0000006F);
        test_basic();
        test_error();
        test_full();
        test_load_collision();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-fetch responder for the single-cycle core: accepts word-fetch requests carrying a byte PC and returns the 32-bit instruction word from an internal word-addressed memory after a fixed pipeline latency. It sits between the core's fetch port and its instruction store. It provides in-order responses, credit-based backpressure and an error response for out-of-range or misaligned PCs. A side load port lets the bench or loader preload the image.

## Interface
Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0
- DEPTH_WORDS, 1024, memory size in 32-bit words (power of two)
- LATENCY, 2, accept-to-response cycles; legal 1..4
- FIFO_DEPTH, 4, response buffer entries; also the maximum number of in-flight requests (power of two, ≥ LATENCY)
- ERR_INST, 32'h00100073, data returned on error (ebreak encoding)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept
- req_addr  in  32  byte PC
- rsp_valid  out  1  response at FIFO head
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  32  instruction word, or ERR_INST on error
- rsp_err  out  1  request was out of range or misaligned
- ld_en  in  1  memory write strobe
- ld_addr  in  log2(DEPTH_WORDS)  word index
- ld_data  in  32  word to write
- rsp_cnt  out  32  count of responses consumed

## Operation
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Check: a request is legal iff req_addr[1:0]==0 and BASE_ADDR ≤ req_addr < BASE_ADDR+4*DEPTH_WORDS.
  - Unsigned 32-bit comparison.
  - Word index = (req_addr-BASE_ADDR)>>2.
- Legal request: reads mem[index]; rsp_err=0.
- Illegal request: no memory access; rsp_data=ERR_INST, rsp_err=1.
- Pipeline: LATENCY-stage shift register of {valid, data, err}. The final stage writes into the response FIFO.
- Credits: inflight (pipeline valids) + occupancy (FIFO entries) ≤ FIFO_DEPTH at all times.
  - req_ready = (inflight+occupancy) < FIFO_DEPTH.
  - req_ready depends only on registered counts, never combinationally on rsp_ready or req_valid.
  - The FIFO therefore never overflows, and the pipeline never stalls.
- Response: rsp_valid = FIFO non-empty. rsp_data and rsp_err show the head entry.
  - Pop on rsp_valid && rsp_ready.
  - Responses come out strictly in acceptance order.
- rsp_cnt increments on each pop and wraps from 2^32-1 to 0.
- Load port: when ld_en=1, mem[ld_addr] ← ld_data at the edge.
  - A fetch of the same word in the same cycle returns the old data (read-before-write).
  - The load port never blocks fetches.
- Reset:
  - Clears the pipeline valids, FIFO pointers, counts and rsp_cnt.
  - Memory contents are not reset.
  - Requests presented during reset are not accepted.
  - A reset asserted mid-operation discards all in-flight and buffered responses; none are emitted afterward.

## Timing
- Reset values: req_ready=0 while reset=1, then 1 in the first cycle after deassertion. rsp_valid=0, rsp_err=0, rsp_data=ERR_INST (empty head), rsp_cnt=0.
- Latency:
  - A request accepted at edge of cycle t gives rsp_valid in cycle t+LATENCY, provided earlier responses have drained.
  - Otherwise it appears the cycle after its predecessor pops.
- Throughput: one request per cycle while rsp_ready is held high, given FIFO_DEPTH ≥ LATENCY+1.
  - With FIFO_DEPTH == LATENCY, throughput is limited by credit return.
- Simultaneous accept and pop: both take effect. The count changes by net 0, and req_ready in the next cycle reflects the updated count.
- Full: when inflight+occupancy == FIFO_DEPTH, req_ready=0 until a pop occurs. req_ready rises in the cycle after the pop edge.
- Empty with rsp_ready=1: no pop occurs, and rsp_cnt is unchanged.
- Hold rule: while rsp_valid=1 && rsp_ready=0, rsp_data and rsp_err are stable.

## Test plan
- Preload mem[0]=32'h00500093 and mem[1]=32'h00108113. Request 32'h80000000 then 32'h80000004 back-to-back with rsp_ready=1 → responses in cycles t+2 and t+3, data in order, rsp_err=0, rsp_cnt=2.
- Request 32'h80001000 (one past end, DEPTH_WORDS=1024) → rsp_data=32'h00100073, rsp_err=1. Request 32'h80000002 → the same error response.
- Hold rsp_ready=0 and present req_valid continuously → exactly 4 accepts, then req_ready=0. Raise rsp_ready → 4 responses in order, with req_ready returning 1 cycle after the first pop.
- Same cycle: ld_en writes mem[3]=32'hDEADBEEF while 32'h8000000C is fetched (old value 32'h00000013) → response 32'h00000013. A refetch returns 32'hDEADBEEF.
- Accept 3 requests, then assert reset for 1 cycle mid-flight → no rsp_valid after reset, rsp_cnt=0, req_ready=1 one cycle after deassertion.
- Random req_valid/rsp_ready toggling over 1000 cycles against a scoreboard → in-order data match, no lost or duplicated responses, invariant inflight+occupancy ≤ 4.
